// File: rtl/demux_scan_pkg.sv
// rtl/demux_scan_pkg.sv - shared constants and FSM state type for the demux scan sequencer
package demux_scan_pkg;
  localparam int NUM_CH      = 16;
  localparam int SEL_W       = $clog2(NUM_CH);
  localparam int DWELL_W_DEF = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/demux_dwell_timer.sv
// rtl/demux_dwell_timer.sv - per-channel dwell counter with one-cycle tick on count == dwell
module demux_dwell_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] dwell_i,
  input  logic         run_i,
  input  logic         clr_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] dwell_q;

  // Equality compare only, so an all-ones dwell never needs the counter to overflow.
  assign tick_o = run_i && (cnt_q == dwell_q);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) dwell_q <= dwell_i;
    end
  end
endmodule

// File: rtl/demux_scan_seq.sv
// rtl/demux_scan_seq.sv - channel-walking sequencer feeding the 1:16 LED demux
// DEMUX_SCAN_LOOP_EN adds the stop input and continuous re-latching passes.
module demux_scan_seq
  import demux_scan_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef DEMUX_SCAN_LOOP_EN
  input  logic               stop,
`endif
  input  logic [NUM_CH-1:0]  pattern,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               d,
  output logic               busy,
  output logic               done
);
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_CH-1:0]  pat_q, pat_d;
  logic               done_q, done_d;
  logic               load;
  logic               tick;
  logic               last_ch;
  logic               finish;

  assign last_ch = (sel_q == SEL_W'(NUM_CH - 1));

`ifdef DEMUX_SCAN_LOOP_EN
  logic stop_q, stop_d;

  // A stop request is remembered so the current pass always completes.
  assign finish = stop_q || stop;
  assign stop_d = (state_q == ST_SCAN) ? (stop_q || stop) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) stop_q <= 1'b0;
    else     stop_q <= stop_d;
  end
`else
  assign finish = 1'b1;
`endif

  demux_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .dwell_i (dwell),
    .run_i   (state_q == ST_SCAN),
    .clr_i   (state_q != ST_SCAN),
    .tick_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      pat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          pat_d   = pattern;
          sel_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          if (!last_ch) begin
            sel_d = sel_q + SEL_W'(1);
          end else if (finish) begin
            sel_d   = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Wrap into the next pass with a fresh pattern; dwell stays latched.
            sel_d  = '0;
            pat_d  = pattern;
            done_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en   = 1'b0;
    busy = 1'b0;
    d    = 1'b0;
    if (state_q == ST_SCAN) begin
      en   = 1'b1;
      busy = 1'b1;
      d    = pat_q[sel_q];
    end
  end

  assign sel  = sel_q;
  assign done = done_q;
endmodule

// File: tb/tb_demux_scan_seq.sv
// tb/tb_demux_scan_seq.sv - self-checking bench for demux_scan_seq against a cycle-index scan model
module tb_demux_scan_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pattern;
  logic [25:0] dwell;
  logic [3:0]  sel;
  logic        en, d, busy, done;
`ifdef DEMUX_SCAN_LOOP_EN
  logic        stop;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  demux_scan_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef DEMUX_SCAN_LOOP_EN
    .stop    (stop),
`endif
    .pattern (pattern),
    .dwell   (dwell),
    .sel     (sel),
    .en      (en),
    .d       (d),
    .busy    (busy),
    .done    (done)
  );

  function automatic logic [7:0] obs();
    return {sel, en, d, busy, done};
  endfunction

  // Expected {sel,en,d,busy,done} t cycles after the accepted start edge.
  function automatic logic [7:0] exp_scan(input logic [15:0] pat, input int dw, input int t);
    int total = 16 * (dw + 1);
    int s;
    if (t >= 1 && t <= total) begin
      s = (t - 1) / (dw + 1);
      return {4'(s), 1'b1, pat[s], 1'b1, 1'b0};
    end
    if (t == total + 1) return 8'b0000_0001;
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    vectors++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed sel/en/d/busy/done=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [15:0] pat, input int dw, input bit meddle, input bit abort);
    int total = 16 * (dw + 1);
    pattern = pat;
    dwell   = 26'(dw);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= total + 2; t++) begin
      check("scan", obs(), exp_scan(pat, dw, t));
      if (abort && t == 7 * (dw + 1) + 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_reset", obs(), 8'h00);
        tick();
        check("abort_nodone", obs(), 8'h00);
        return;
      end
      if (meddle && t <= total + 1) begin
        start   = 1'($urandom_range(0, 1));
        pattern = 16'hFFFF;
        dwell   = 26'($urandom);
      end
      if (t < total + 2) tick();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] p;
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 16'h0;
    dwell   = 26'h0;
`ifdef DEMUX_SCAN_LOOP_EN
    stop    = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", obs(), 8'h00);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle", obs(), 8'h00);
    end

    scan(16'hA5C3, 0, 1'b0, 1'b0);
    scan(16'h0001, 3, 1'b0, 1'b0);
    scan(16'h3C69, 1, 1'b1, 1'b0);
    scan(16'h9F21, 1, 1'b0, 1'b1);
    scan(16'h6B5D, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      scan(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Maximum dwell: channel 0 must hold without the counter wrapping early.
    p       = 16'($urandom);
    pattern = p;
    dwell   = '1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("max_dwell", obs(), {4'd0, 1'b1, p[0], 1'b1, 1'b0});
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("max_dwell_reset", obs(), 8'h00);

`ifdef DEMUX_SCAN_LOOP_EN
    begin
      logic [15:0] p1, p2;
      p1 = 16'($urandom);
      p2 = ~p1;
      pattern = p1;
      dwell   = 26'd0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 1; t <= 34; t++) begin
        if (t <= 16)
          check("loop_p1", obs(), {4'(t - 1), 1'b1, p1[t - 1], 1'b1, 1'b0});
        else if (t <= 32)
          check("loop_p2", obs(), {4'(t - 17), 1'b1, p2[t - 17], 1'b1, 1'(t == 17)});
        else if (t == 33)
          check("loop_done", obs(), 8'b0000_0001);
        else
          check("loop_idle", obs(), 8'h00);
        if (t == 16) pattern = p2;
        stop = (t == 20);
        if (t < 34) tick();
      end
      stop = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
